// File: rtl/video_pkg.sv
// Shared definitions for the video fetch scheduler.
//   bw_e      : bandwidth codes delivered by the video mode decoder
//   state_e   : scheduler FSM states
//   SLOT_W    : width of the DRAM-cycle slot counter (8-slot window)
//   slot_eligible() : slot qualification for a given bandwidth code
package video_pkg;

  localparam int SLOT_W = 3;

  typedef enum logic [1:0] {
    BW_1_8 = 2'b00,
    BW_1_4 = 2'b01,
    BW_1_2 = 2'b10,
    BW_1   = 2'b11
  } bw_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  function automatic logic slot_eligible(input logic [1:0] bw, input logic [SLOT_W-1:0] slot);
    logic ok;
    case (bw)
      BW_1:    ok = 1'b1;
      BW_1_2:  ok = (slot[0] == 1'b0);
      BW_1_4:  ok = (slot[1:0] == 2'b00);
      default: ok = (slot == '0);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/video_fetch_sched_if.sv
// Bus bundle between the fetch scheduler and its neighbours.
//   video_go     : request pulse to the DRAM arbiter
//   video_strobe : returned word valid on video_data
//   video_data   : returned DRAM word
//   pix_rd       : pop request from the pixel shifter
//   pix_data     : FIFO head word (show-ahead)
//   pix_valid    : FIFO not empty
// master = scheduler side, slave = arbiter/shifter side.
interface video_fetch_sched_if;
  logic        video_go;
  logic        video_strobe;
  logic [15:0] video_data;
  logic        pix_rd;
  logic [15:0] pix_data;
  logic        pix_valid;

  modport master (
    output video_go,
    input  video_strobe,
    input  video_data,
    input  pix_rd,
    output pix_data,
    output pix_valid
  );

  modport slave (
    input  video_go,
    output video_strobe,
    output video_data,
    output pix_rd,
    input  pix_data,
    input  pix_valid
  );
endinterface

// File: rtl/video_fetch_fifo.sv
// Show-ahead FIFO, 16 bits wide, DEPTH words (power of 2, >= 2).
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i/din_i : write a word
//   pop_i        : advance the head
//   flush_i      : empty the FIFO (dominates push/pop)
//   dout_o       : head word, forced to 0 while empty
//   count_o, empty_o, full_o : occupancy status
module video_fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [15:0]             din_i,
  output logic [15:0]             dout_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o,
  output logic                    full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_C);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = count_q;
  assign dout_o  = empty_o ? 16'h0000 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage has no reset; the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/video_fetch_sched.sv
// Per-line DRAM fetch scheduler for the video engine.
// Issues requests in an 8-slot DRAM-cycle window according to the bandwidth
// code, collects returned words in a show-ahead FIFO and never lets
// FIFO words + requests in flight exceed the FIFO depth. Returns belonging to
// a restarted line are discarded.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   cbeg_i         : start-of-DRAM-cycle strobe
//   mode_bw_i      : bandwidth code (00=1/8 .. 11=1)
//   line_start_i   : begin a new line; line_words_i sampled here
//   vid_if         : arbiter request/return and pixel-shifter FIFO port
//   fetch_busy_o   : state is FETCH or DRAIN
//   underrun_o     : sticky, pop attempted on empty FIFO
// Optional (macro VIDEO_FETCH_STATS_EN): err_cnt_o (saturating empty-pop
// count) and peak_occ_o (highest FIFO occupancy); both cleared by reset only.
//
// state   | meaning
// S_IDLE  | no line active
// S_FETCH | words of the current line still to be requested
// S_DRAIN | all requested, waiting for outstanding returns
module video_fetch_sched
  import video_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WCNT_W     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cbeg_i,
  input  logic [1:0]            mode_bw_i,
  input  logic                  line_start_i,
  input  logic [WCNT_W-1:0]     line_words_i,
  video_fetch_sched_if.master   vid_if,
  output logic                  fetch_busy_o,
  output logic                  underrun_o
`ifdef VIDEO_FETCH_STATS_EN
  ,
  output logic [7:0]                    err_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   peak_occ_o
`endif
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int DISC_W = CNT_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [WCNT_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic [DISC_W-1:0]   discard_q, discard_d;
  logic                go_q, go_d;
  logic                underrun_q, underrun_d;

  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic                push_req, issue, strobe_drop, strobe_take, empty_pop;
  logic [CNT_W:0]      occ_sum;
  logic [DISC_W:0]     in_flight;

  assign occ_sum     = {1'b0, fifo_count} + {1'b0, outstanding_q};
  // No issue on the line_start clock: counters are being reloaded then.
  assign issue       = cbeg_i && !line_start_i && (state_q == S_FETCH) &&
                       slot_eligible(mode_bw_i, slot_q) &&
                       (remaining_q != '0) && (occ_sum < DEPTH_C);
  assign strobe_drop = vid_if.video_strobe && (discard_q != '0);
  assign strobe_take = vid_if.video_strobe && (discard_q == '0) && (outstanding_q != '0);
  assign push_req    = strobe_take && !line_start_i;
  assign fifo_push   = push_req && !fifo_full;
  assign fifo_pop    = vid_if.pix_rd && !fifo_empty && !line_start_i;
  assign empty_pop   = vid_if.pix_rd && fifo_empty;

  video_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (line_start_i),
    .din_i   (vid_if.video_data),
    .dout_o  (vid_if.pix_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    slot_d        = slot_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    underrun_d    = underrun_q;
    go_d          = issue;
    in_flight     = '0;

    if (line_start_i)  slot_d = '0;
    else if (cbeg_i)   slot_d = slot_q + 1'b1;

    if (line_start_i) begin
      remaining_d   = line_words_i;
      outstanding_d = '0;
      // Everything still in flight becomes stale, including earlier stale
      // returns; a concurrent strobe is the first of them.
      in_flight = {1'b0, discard_q} + (DISC_W+1)'(outstanding_q);
      if (vid_if.video_strobe && (in_flight != '0)) in_flight = in_flight - 1'b1;
      discard_d = in_flight[DISC_W] ? '1 : in_flight[DISC_W-1:0];
    end else begin
      if (issue) remaining_d = remaining_q - 1'b1;
      if (issue && !strobe_take)      outstanding_d = outstanding_q + 1'b1;
      else if (strobe_take && !issue) outstanding_d = outstanding_q - 1'b1;
      if (strobe_drop) discard_d = discard_q - 1'b1;
    end

    if (line_start_i)   underrun_d = 1'b0;
    else if (empty_pop) underrun_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_FETCH: if (remaining_q == '0) state_d = S_DRAIN;
      S_DRAIN: if ((outstanding_q == '0) && !vid_if.video_strobe) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (line_start_i) state_d = (line_words_i != '0) ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      slot_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      go_q          <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      go_q          <= go_d;
      underrun_q    <= underrun_d;
    end
  end

  assign vid_if.video_go  = go_q;
  assign vid_if.pix_valid = !fifo_empty;
  assign fetch_busy_o     = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign underrun_o       = underrun_q;

`ifdef VIDEO_FETCH_STATS_EN
  logic [7:0]       err_cnt_q;
  logic [CNT_W-1:0] peak_occ_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q  <= '0;
      peak_occ_q <= '0;
    end else begin
      if (empty_pop && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 1'b1;
      if (fifo_count > peak_occ_q) peak_occ_q <= fifo_count;
    end
  end

  assign err_cnt_o  = err_cnt_q;
  assign peak_occ_o = peak_occ_q;
`else
  // Statistics disabled: only the sticky underrun flag is provided.
`endif
endmodule

// File: tb/tb_video_fetch_sched.sv
// Scoreboard bench for video_fetch_sched: returned words are queued when the
// bench drives them and checked when the pixel side pops; request pulses are
// checked against hand-computed slot positions relative to line_start.
module tb_video_fetch_sched;
  localparam int FIFO_DEPTH = 4;
  localparam int WCNT_W     = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cbeg = 1'b0;
  logic              line_start = 1'b0;
  logic [1:0]        mode_bw = 2'b00;
  logic [WCNT_W-1:0] line_words = '0;
  logic              fetch_busy, underrun;
`ifdef VIDEO_FETCH_STATS_EN
  logic [7:0]        err_cnt;
  logic [2:0]        peak_occ;
`endif

  video_fetch_sched_if ifc();

  video_fetch_sched #(.FIFO_DEPTH(FIFO_DEPTH), .WCNT_W(WCNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cbeg_i       (cbeg),
    .mode_bw_i    (mode_bw),
    .line_start_i (line_start),
    .line_words_i (line_words),
    .vid_if       (ifc),
    .fetch_busy_o (fetch_busy),
    .underrun_o   (underrun)
`ifdef VIDEO_FETCH_STATS_EN
    ,
    .err_cnt_o    (err_cnt),
    .peak_occ_o   (peak_occ)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int go_cnt = 0;
  int rel = 0;
  int drop_n = 0;
  int base;
  bit auto_cbeg = 1'b0, auto_pop = 1'b0, resp_en = 1'b0, go_chk = 1'b0;
  logic [15:0] resp_data = 16'hA000;
  logic [15:0] exp_q[$];
  int exp_go[$];
  int due_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_strobe(input logic [15:0] d);
    ifc.video_strobe = 1'b1;
    ifc.video_data   = d;
    if (drop_n > 0) drop_n--;
    else exp_q.push_back(d);
  endtask

  // Advance one clock; record request pulses, then set up the next cycle.
  task automatic step();
    int e;
    @(posedge clk); #1;
    cyc++;
    if (ifc.video_go) begin
      go_cnt++;
      if (go_chk) begin
        e = (exp_go.size() != 0) ? exp_go.pop_front() : -1;
        chk("go_slot", rel, e);
      end
      if (resp_en) due_q.push_back(cyc + 2);
    end
    if (line_start) rel = 0;
    else if (cbeg)  rel++;
    line_start = 1'b0;
    cbeg = 1'b0;
    ifc.video_strobe = 1'b0;
    ifc.pix_rd = auto_pop && ifc.pix_valid;
    if (auto_cbeg && (cyc % 4 == 0)) cbeg = 1'b1;
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      drive_strobe(resp_data);
      resp_data++;
    end
  endtask

  task automatic send_strobe(input logic [15:0] d);
    drive_strobe(d);
    step();
  endtask

  task automatic wait_go(input int n, input int budget);
    for (int i = 0; i < budget && go_cnt < n; i++) step();
    chk("go_count_reached", go_cnt, n);
  endtask

  // Pop monitor and full-push watchdog.
  always @(negedge clk) begin
    if (ifc.pix_rd && ifc.pix_valid) begin
      if (exp_q.size() == 0) chk("pix_unexpected", {16'h0, ifc.pix_data}, 32'hFFFF_FFFF);
      else chk("pix_data", {16'h0, ifc.pix_data}, {16'h0, exp_q.pop_front()});
    end
    if (dut.push_req) chk("push_not_full", dut.fifo_full, 0);
  end

  initial begin
    ifc.video_strobe = 1'b0;
    ifc.video_data   = 16'h0;
    ifc.pix_rd       = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_go", ifc.video_go, 0);
    chk("rst_valid", ifc.pix_valid, 0);
    chk("rst_data", ifc.pix_data, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_underrun", underrun, 0);
`ifdef VIDEO_FETCH_STATS_EN
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_peak", peak_occ, 0);
`endif
    rst = 1'b0;
    step();

    // A: 1/8 bandwidth, 4 words, responses 2 clk after each request
    mode_bw = 2'b00; resp_en = 1'b1; go_chk = 1'b1;
    exp_go = '{0, 8, 16, 24};
    line_start = 1'b1; line_words = 8'd4;
    step();
    chk("a_busy", fetch_busy, 1);
    auto_cbeg = 1'b1;
    wait_go(4, 200);
    repeat (8) step();
    chk("a_idle", fetch_busy, 0);
    chk("a_valid", ifc.pix_valid, 1);
    repeat (4) begin ifc.pix_rd = 1'b1; step(); end
    chk("a_empty", ifc.pix_valid, 0);
    chk("a_sb_empty", exp_q.size(), 0);

    // B: full bandwidth, 10 words, no pops -> stalls at FIFO depth
    mode_bw = 2'b11; exp_q.delete();
    exp_go = '{0, 1, 2, 3};
    line_start = 1'b1; line_words = 8'd10;
    step();
    base = go_cnt;
    wait_go(base + 4, 100);
    repeat (40) step();
    chk("b_stall", go_cnt, base + 4);
    go_chk = 1'b0;
    ifc.pix_rd = 1'b1; step();
    repeat (40) step();
    chk("b_one_more", go_cnt, base + 5);
    chk("b_busy", fetch_busy, 1);

    // C: 1/2 bandwidth changed to 1/4 mid-line
    exp_q.delete(); auto_pop = 1'b1; mode_bw = 2'b10; go_chk = 1'b1;
    exp_go = '{0, 2, 4, 8, 12, 16, 20, 24};
    line_start = 1'b1; line_words = 8'd8;
    step();
    base = go_cnt;
    wait_go(base + 3, 100);
    mode_bw = 2'b01;
    wait_go(base + 8, 300);
    repeat (10) step();
    chk("c_idle", fetch_busy, 0);
    chk("c_go_all_seen", exp_go.size(), 0);
    auto_pop = 1'b0;
    step();
    chk("c_sb_empty", exp_q.size(), 0);

    // D: restart with two requests in flight -> two stale returns dropped
    resp_en = 1'b0; go_chk = 1'b0; mode_bw = 2'b11; exp_q.delete();
    line_start = 1'b1; line_words = 8'd4;
    step();
    base = go_cnt;
    wait_go(base + 2, 50);
    auto_cbeg = 1'b0; cbeg = 1'b0;
    drop_n = 2; exp_q.delete();
    line_start = 1'b1; line_words = 8'd3;
    step();
    chk("d_busy", fetch_busy, 1);
    auto_cbeg = 1'b1;
    wait_go(base + 3, 50);
    auto_cbeg = 1'b0; cbeg = 1'b0;
    send_strobe(16'h1111);
    chk("d_drop1", ifc.pix_valid, 0);
    send_strobe(16'h2222);
    chk("d_drop2", ifc.pix_valid, 0);
    send_strobe(16'h3333);
    chk("d_keep", ifc.pix_valid, 1);
    ifc.pix_rd = 1'b1; step();
    chk("d_sb_empty", exp_q.size(), 0);
    chk("d_empty", ifc.pix_valid, 0);

    // E: pop on empty sets sticky underrun; line_start clears it
    ifc.pix_rd = 1'b1; step();
    chk("e_underrun", underrun, 1);
    chk("e_valid", ifc.pix_valid, 0);
`ifdef VIDEO_FETCH_STATS_EN
    chk("e_err_cnt1", err_cnt, 1);
`endif
    line_start = 1'b1; line_words = 8'd0;
    step();
    chk("e_underrun_clr", underrun, 0);
    chk("e_idle", fetch_busy, 0);
`ifdef VIDEO_FETCH_STATS_EN
    repeat (300) begin ifc.pix_rd = 1'b1; step(); end
    chk("e_err_sat", err_cnt, 255);
    chk("e_peak", peak_occ, 4);
    chk("e_underrun_again", underrun, 1);
`endif

    // F: reset mid-fetch with one request outstanding; late return ignored
    line_start = 1'b1; line_words = 8'd5;
    step();
    base = go_cnt;
    auto_cbeg = 1'b1;
    wait_go(base + 1, 50);
    auto_cbeg = 1'b0; cbeg = 1'b0;
    chk("f_busy", fetch_busy, 1);
    rst = 1'b1;
    step();
    chk("f_rst_go", ifc.video_go, 0);
    chk("f_rst_valid", ifc.pix_valid, 0);
    chk("f_rst_data", ifc.pix_data, 0);
    chk("f_rst_busy", fetch_busy, 0);
    chk("f_rst_underrun", underrun, 0);
`ifdef VIDEO_FETCH_STATS_EN
    chk("f_rst_err_cnt", err_cnt, 0);
    chk("f_rst_peak", peak_occ, 0);
`endif
    rst = 1'b0;
    drop_n = 1;
    send_strobe(16'h5555);
    step();
    chk("f_late_ignored", ifc.pix_valid, 0);
    chk("f_late_idle", fetch_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_fetch_sched.md
Name: video_fetch_sched

Overview:
- Sits directly downstream of the video mode decoder and consumes its 2-bit bandwidth code (`mode_bw`).
- Schedules per-line DRAM fetch requests for the video engine inside an 8-slot DRAM-cycle window.
- Collects the returned 16-bit words in a small show-ahead FIFO that feeds the pixel shifter.
- Tracks requests in flight so the FIFO never overflows, and discards stale returns after a line restart.

Parameters:
- FIFO_DEPTH, 4, FIFO depth in 16-bit words; must be a power of 2 and at least 2.
- WCNT_W, 8, width of the per-line word counter.

Ports:
- clk  in  1  system clock (28 MHz domain).
- rst  in  1  synchronous, active-high reset.
- cbeg  in  1  one-clk strobe marking the start of each DRAM cycle.
- mode_bw  in  2  required bandwidth: 00=1/8, 01=1/4, 10=1/2, 11=1.
- line_start  in  1  one-clk strobe that begins fetching a new line.
- line_words  in  WCNT_W  number of words to fetch this line; sampled on line_start.
- video_go  out  1  one-clk request pulse to the DRAM arbiter.
- video_strobe  in  1  one-clk pulse: returned word is valid on video_data.
- video_data  in  16  returned DRAM word.
- pix_rd  in  1  pop request from the pixel shifter.
- pix_data  out  16  FIFO head word (show-ahead).
- pix_valid  out  1  FIFO not empty.
- fetch_busy  out  1  high while the state is FETCH or DRAIN.
- underrun  out  1  sticky flag: pop attempted while the FIFO was empty.

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, all counters 0.
- slot[2:0] increments on every cbeg and wraps 7->0.
- line_start forces slot to 0. If cbeg arrives in the same clock, slot is still 0 after that clock.
- A slot is eligible when:
  - mode_bw=11: every slot.
  - mode_bw=10: slot[0]==0.
  - mode_bw=01: slot[1:0]==0.
  - mode_bw=00: slot==0.
  - mode_bw is sampled on each cbeg. A change takes effect on the next cbeg.
- Issue condition, all on a cbeg clock: state==FETCH, slot eligible, remaining!=0, and (fifo_count + outstanding) < FIFO_DEPTH.
- On issue:
  - video_go is asserted in the following clock (latency 1).
  - remaining decrements by 1.
  - outstanding increments by 1; outstanding saturates at FIFO_DEPTH by construction.
- State machine:
  - IDLE -> FETCH on line_start with line_words!=0. line_start with line_words==0 stays in IDLE, but still flushes.
  - FETCH -> DRAIN when remaining reaches 0.
  - DRAIN -> IDLE when outstanding==0 and no strobe is pending.
  - line_start in any state reloads remaining and flushes the FIFO, then enters FETCH (or IDLE if line_words==0).
- Stale returns: on line_start, discard is loaded with the current outstanding and outstanding is cleared.
  - Each video_strobe decrements discard if it is non-zero; the word is dropped.
  - Otherwise the strobe decrements outstanding and pushes video_data into the FIFO.
- Strobe with both outstanding==0 and discard==0: ignored, and counters do not change.
- FIFO push and pop in the same clock: count unchanged and head advances. Push to a full FIFO is impossible by construction; the bench asserts it never happens.
- Pop on empty: ignored and underrun set to 1. underrun clears only on rst or line_start.
- line_start concurrent with a strobe: the strobe counts against discard, computed from the outstanding value before line_start.
- Widths: remaining is WCNT_W bits. fifo_count and outstanding are clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: VIDEO_FETCH_STATS_EN.
- Defined:
  - Adds output `err_cnt[7:0]`, a saturating count of empty pops; it stops at 255.
  - Adds output `peak_occ[clog2(FIFO_DEPTH):0]`, the maximum fifo_count seen.
  - Both clear only on rst.
- Undefined: neither port exists and only the sticky underrun flag remains.

Decomposition:
- Shared package video_pkg holds:
  - BW_1_8, BW_1_4, BW_1_2, BW_1 encodings (2-bit).
  - State constants S_IDLE, S_FETCH, S_DRAIN.
  - SLOT_W=3.
- Sub-module video_fetch_fifo:
  - Parameterised depth, 16-bit wide, show-ahead.
  - Push, pop, flush, count, empty, full.

Test Plan:
- mode_bw=00, line_words=4, strobe 2 clk after each video_go, no pops -> video_go only at slot 0, i.e. one per 8 cbeg. 4 words are pushed in order. DRAIN then IDLE; fetch_busy falls after the 4th strobe.
- mode_bw=11, line_words=10, FIFO_DEPTH=4, no pops -> exactly 4 requests are issued, then issue stalls with fifo_count=4. Popping one word allows exactly one more request.
- mode_bw=10 then 01 changed mid-line -> request spacing changes from every 2nd cbeg to every 4th cbeg, starting at the next cbeg.
- line_start while outstanding=2 -> the next 2 strobes are dropped (FIFO stays empty); the 3rd strobe's word is pushed as word 0 of the new line.
- pix_rd on empty FIFO -> underrun=1, pix_valid=0. The next line_start clears underrun. With VIDEO_FETCH_STATS_EN, err_cnt=1 and it saturates at 255 after 300 empty pops.
- rst asserted mid-FETCH with outstanding=1 -> the next clock shows all outputs 0 and IDLE. The late strobe is ignored and no push occurs.
